// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: FSM state encoding,
// RV32I load/store func3 constants, access-size enum and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } dmem_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only know B/H/W; the unsigned load codes fall back to word for stores.
  function automatic dmem_size_e f3_size(input logic [2:0] f3, input logic is_store);
    dmem_size_e sz;
    if (is_store) begin
      case (f3)
        F3_B:    sz = SZ_B;
        F3_H:    sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: sz = SZ_B;
        F3_H, F3_HU: sz = SZ_H;
        default:     sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3, input logic is_store);
    return !is_store && ((f3 == F3_B) || (f3 == F3_H));
  endfunction

  function automatic logic is_misaligned(input dmem_size_e sz, input logic [1:0] addr_lo);
    logic mis;
    case (sz)
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bundle between the pipeline MEM stage (master) and the
// data-memory responder (slave).
//   MemRead/MemWrite/addr/wr_data/func3 : request, held stable while mem_stall
//   rd_data/rd_valid/mem_stall          : response and hold request
//   misalign                            : only with DMEM_MISALIGN_TRAP_EN
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);

  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] addr;
  logic [DATA_W-1:0]     wr_data;
  logic [2:0]            func3;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  mem_stall;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic                  misalign;
`endif

`ifdef DMEM_MISALIGN_TRAP_EN
  modport master (
    output MemRead, MemWrite, addr, wr_data, func3,
    input  rd_data, rd_valid, mem_stall, misalign
  );
  modport slave (
    input  MemRead, MemWrite, addr, wr_data, func3,
    output rd_data, rd_valid, mem_stall, misalign
  );
`else
  modport master (
    output MemRead, MemWrite, addr, wr_data, func3,
    input  rd_data, rd_valid, mem_stall
  );
  modport slave (
    input  MemRead, MemWrite, addr, wr_data, func3,
    output rd_data, rd_valid, mem_stall
  );
`endif

endinterface

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering for a 32-bit word memory.
//   i_addr_lo  : byte offset within the word
//   i_func3    : RV32I load/store size/sign code
//   i_is_store : selects store vs load decoding of i_func3
//   i_wr_data  : right-aligned store data
//   i_rd_word  : full word read from storage
//   o_wmask    : byte write enables
//   o_wdata    : store data replicated onto every candidate lane
//   o_ld_data  : selected and extended load result
// Halfword and word accesses are force-aligned here (low address bits ignored).
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_func3,
  input  logic        i_is_store,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_rd_word,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  dmem_size_e  w_size;
  logic        w_sext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Decode size and signedness of the access
  always_comb begin
    w_size = f3_size(i_func3, i_is_store);
    w_sext = f3_signed(i_func3, i_is_store);
  end

  // Pick the addressed byte and halfword out of the stored word
  always_comb begin
    case (i_addr_lo)
      2'b00:   w_byte = i_rd_word[7:0];
      2'b01:   w_byte = i_rd_word[15:8];
      2'b10:   w_byte = i_rd_word[23:16];
      2'b11:   w_byte = i_rd_word[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_rd_word[31:16];
    end else begin
      w_half = i_rd_word[15:0];
    end
  end

  // Build the write mask, lane data and extended load value
  always_comb begin
    o_wmask   = 4'b0000;
    o_wdata   = 32'h0000_0000;
    o_ld_data = 32'h0000_0000;
    case (w_size)
      SZ_B: begin
        o_wmask = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wr_data[7:0]}};
        if (w_sext) begin
          o_ld_data = {{24{w_byte[7]}}, w_byte};
        end else begin
          o_ld_data = {24'h000000, w_byte};
        end
      end
      SZ_H: begin
        o_wmask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wr_data[15:0]}};
        if (w_sext) begin
          o_ld_data = {{16{w_half[15]}}, w_half};
        end else begin
          o_ld_data = {16'h0000, w_half};
        end
      end
      default: begin
        o_wmask   = 4'b1111;
        o_wdata   = i_wr_data;
        o_ld_data = i_rd_word;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Wait-state data memory for a pipelined core. Each access is captured in
// IDLE, spends WAIT_CYCLES cycles in WAIT, then answers with a one-cycle
// rd_valid pulse in RESP. Stores commit at the edge that ends RESP.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high; aborts any access, storage untouched
//   bus   : dmem_responder_if slave (request in, rd_data/rd_valid/mem_stall out)
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- flags misaligned accesses
// on bus.misalign, suppresses their store and returns 0 for their loads.
// Without it, misaligned halfword/word addresses are force-aligned.
// Lane logic assumes DATA_W = 32.
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int         C_DEPTH     = 2 ** (DM_ADDRESS - 2);
  localparam bit         C_NO_WAIT   = (WAIT_CYCLES == 32'sd0);
  localparam logic [3:0] C_WAIT_LAST = (WAIT_CYCLES > 32'sd0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [DATA_W-1:0]     r_mem [C_DEPTH];

  dmem_state_e           r_state;
  logic [3:0]            r_cnt;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [2:0]            r_func3;
  logic                  r_is_store;
  logic [DATA_W-1:0]     r_rd_data;
  logic                  r_rd_valid;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic                  r_misalign;
`endif

  logic                  w_req;
  logic                  w_stall;
  logic                  w_resp_entry;
  logic [DM_ADDRESS-1:0] w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [2:0]            w_func3;
  logic                  w_is_store;
  logic [DATA_W-1:0]     w_rd_word;
  logic [3:0]            w_wmask;
  logic [DATA_W-1:0]     w_st_data;
  logic [DATA_W-1:0]     w_ld_data;
  logic                  w_misal;

  assign w_req = bus.MemRead | bus.MemWrite;

  // Live bus fields in IDLE (needed when WAIT_CYCLES=0), captured copy afterwards
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_addr     = bus.addr;
      w_wdata    = bus.wr_data;
      w_func3    = bus.func3;
      w_is_store = bus.MemWrite;
    end else begin
      w_addr     = r_addr;
      w_wdata    = r_wdata;
      w_func3    = r_func3;
      w_is_store = r_is_store;
    end
  end

  assign w_rd_word = r_mem[w_addr[DM_ADDRESS-1:2]];

  dmem_lane_align u_lane_align (
    .i_addr_lo  (w_addr[1:0]),
    .i_func3    (w_func3),
    .i_is_store (w_is_store),
    .i_wr_data  (w_wdata),
    .i_rd_word  (w_rd_word),
    .o_wmask    (w_wmask),
    .o_wdata    (w_st_data),
    .o_ld_data  (w_ld_data)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_misal = is_misaligned(f3_size(w_func3, w_is_store), w_addr[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  // Hold request: pending request in IDLE, every WAIT cycle; never under reset
  always_comb begin
    w_stall = 1'b0;
    if (reset) begin
      w_stall = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: w_stall = w_req;
        ST_WAIT: w_stall = 1'b1;
        ST_RESP: w_stall = 1'b0;
        default: w_stall = 1'b0;
      endcase
    end
  end

  // Next cycle is the response cycle
  always_comb begin
    w_resp_entry = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req && C_NO_WAIT) begin
          w_resp_entry = 1'b1;
        end else begin
          w_resp_entry = 1'b0;
        end
      end
      ST_WAIT: w_resp_entry = (r_cnt == 4'd0);
      default: w_resp_entry = 1'b0;
    endcase
  end

  // Access FSM with request capture and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_func3    <= 3'b000;
      r_is_store <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_rd_valid <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr     <= bus.addr;
            r_wdata    <= bus.wr_data;
            r_func3    <= bus.func3;
            // MemRead+MemWrite together is a store
            r_is_store <= bus.MemWrite;
            if (C_NO_WAIT) begin
              r_state <= ST_RESP;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= C_WAIT_LAST;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_resp_entry) begin
        r_rd_valid <= 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        r_misalign <= w_misal;
`endif
        // Only loads touch rd_data; a trapped load returns zero
        if (!w_is_store) begin
          r_rd_data <= w_misal ? '0 : w_ld_data;
        end
      end
    end
  end

  // Store commit at the end of RESP; storage is never reset
  always_ff @(posedge clk) begin
    if (!reset && (r_state == ST_RESP) && r_is_store && !w_misal) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) begin
          r_mem[w_addr[DM_ADDRESS-1:2]][8*i +: 8] <= w_st_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.mem_stall = w_stall;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign bus.misalign  = r_misalign;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Two responders share clk/reset: u_dut2 (WAIT_CYCLES=2) runs a table of
// accesses, u_dut0 (WAIT_CYCLES=0) runs back-to-back loads. Expected load
// results are queued at issue and compared when rd_valid appears.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          issue;
  } sb_t;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;
  sb_t  sb2[$];
  sb_t  sb0[$];
  vec_t vecs[$];

  dmem_responder_if #(.DATA_W(32), .DM_ADDRESS(9)) bus2 ();
  dmem_responder_if #(.DATA_W(32), .DM_ADDRESS(9)) bus0 ();

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  dmem_responder #(.DATA_W(32), .DM_ADDRESS(9), .WAIT_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic rd, input logic [8:0] addr,
                              input logic [2:0] f3, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_mis);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.f3 = f3;
    v.wdata = wdata; v.exp_rd = exp_rd; v.exp_mis = exp_mis;
    return v;
  endfunction

  // Issue one access on the selected DUT, push its expectation, wait out the stall
  task automatic run_acc(input int sel, input vec_t v);
    int   stalls;
    bit   done;
    logic st;
    sb_t  s;
    stalls = 0;
    done   = 1'b0;
    @(posedge clk); #1;
    if (sel == 0) begin
      bus0.MemRead = v.rd; bus0.MemWrite = v.wr; bus0.addr = v.addr;
      bus0.func3 = v.f3; bus0.wr_data = v.wdata;
    end else begin
      bus2.MemRead = v.rd; bus2.MemWrite = v.wr; bus2.addr = v.addr;
      bus2.func3 = v.f3; bus2.wr_data = v.wdata;
    end
    s.rd = v.exp_rd; s.mis = v.exp_mis; s.issue = cyc;
    if (sel == 0) sb0.push_back(s);
    else          sb2.push_back(s);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      st = (sel == 0) ? bus0.mem_stall : bus2.mem_stall;
      if (st) stalls++;
      else    done = 1'b1;
    end
    chk("stall_timeout", {31'd0, done}, 32'd1);
    chk((sel == 0) ? "dut0_stall_cycles" : "dut2_stall_cycles", stalls, (sel == 0) ? 32'd1 : 32'd3);
  endtask

  task automatic idle_bus();
    bus0.MemRead = 1'b0; bus0.MemWrite = 1'b0;
    bus2.MemRead = 1'b0; bus2.MemWrite = 1'b0;
  endtask

  // Scoreboard for the WAIT_CYCLES=2 responder
  always @(negedge clk) begin : mon2
    sb_t s;
    if (bus2.rd_valid) begin
      if (sb2.size() == 0) begin
        chk("dut2_unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        s = sb2.pop_front();
        chk("dut2_rd_data", bus2.rd_data, s.rd);
        chk("dut2_latency", cyc - s.issue, 32'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("dut2_misalign", {31'd0, bus2.misalign}, {31'd0, s.mis});
`endif
      end
    end
  end

  // Scoreboard for the WAIT_CYCLES=0 responder
  always @(negedge clk) begin : mon0
    sb_t s;
    if (bus0.rd_valid) begin
      if (sb0.size() == 0) begin
        chk("dut0_unexpected_rd_valid", 32'd1, 32'd0);
      end else begin
        s = sb0.pop_front();
        chk("dut0_rd_data", bus0.rd_data, s.rd);
        chk("dut0_latency", cyc - s.issue, 32'd1);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus0.addr = 9'h000; bus0.func3 = 3'b010; bus0.wr_data = 32'h0;
    bus2.addr = 9'h000; bus2.func3 = 3'b010; bus2.wr_data = 32'h0;
    // Request present during reset must not raise mem_stall
    bus0.MemRead = 1'b1; bus0.MemWrite = 1'b0;
    bus2.MemRead = 1'b1; bus2.MemWrite = 1'b0;

    //            wr    rd    addr    f3      wdata          exp_rd         mis
    vecs.push_back(mk(1'b1, 1'b0, 9'h010, 3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h010, 3'b010, 32'h00000000, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h013, 3'b000, 32'h00000080, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h013, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h013, 3'b100, 32'h0,        32'h00000080, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h010, 3'b010, 32'h0,        32'h80000000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h014, 3'b010, 32'h11223344, 32'h80000000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h016, 3'b001, 32'hFFFF8001, 32'h80000000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h014, 3'b010, 32'h0,        32'h80013344, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h016, 3'b001, 32'h0,        32'hFFFF8001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h016, 3'b101, 32'h0,        32'h00008001, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h014, 3'b001, 32'h0,        32'h00003344, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h015, 3'b000, 32'h0,        32'h00000033, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h017, 3'b100, 32'h0,        32'h00000080, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h014, 3'b000, 32'h000000AA, 32'h00000080, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h014, 3'b011, 32'h0,        32'h800133AA, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h018, 3'b111, 32'hCAFEF00D, 32'h800133AA, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h018, 3'b010, 32'h0,        32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 9'h030, 3'b010, 32'hA5A5A5A5, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h030, 3'b010, 32'h0,        32'hA5A5A5A5, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 9'h020, 3'b010, 32'h00000000, 32'hA5A5A5A5, 1'b0));
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back(mk(1'b1, 1'b0, 9'h021, 3'b001, 32'h0000BEEF, 32'hA5A5A5A5, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 9'h020, 3'b010, 32'h0,        32'h00000000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h022, 3'b010, 32'h0,        32'h00000000, 1'b1));
`else
    vecs.push_back(mk(1'b1, 1'b0, 9'h021, 3'b001, 32'h0000BEEF, 32'hA5A5A5A5, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h020, 3'b010, 32'h0,        32'h0000BEEF, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 9'h022, 3'b010, 32'h0,        32'h0000BEEF, 1'b0));
`endif

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dut2_mem_stall", {31'd0, bus2.mem_stall}, 32'd0);
    chk("rst_dut2_rd_valid",  {31'd0, bus2.rd_valid},  32'd0);
    chk("rst_dut2_rd_data",   bus2.rd_data,            32'd0);
    chk("rst_dut0_mem_stall", {31'd0, bus0.mem_stall}, 32'd0);
    chk("rst_dut0_rd_data",   bus0.rd_data,            32'd0);
    @(posedge clk); #1;
    idle_bus();
    reset = 1'b0;

    // Table on the two-wait-state responder, back to back
    for (int i = 0; i < vecs.size(); i++) begin
      run_acc(2, vecs[i]);
    end
    @(posedge clk); #1;
    idle_bus();
    repeat (2) @(posedge clk);

    // Reset while a store sits in WAIT: store dropped, no response
    #1;
    bus2.MemWrite = 1'b1; bus2.MemRead = 1'b0; bus2.addr = 9'h020;
    bus2.func3 = 3'b010; bus2.wr_data = 32'h12345678;
    @(posedge clk); #1;
    reset = 1'b1;
    idle_bus();
    @(negedge clk);
    chk("abort_mem_stall", {31'd0, bus2.mem_stall}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_rd_valid", {31'd0, bus2.rd_valid}, 32'd0);
    chk("abort_rd_data",  bus2.rd_data,           32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    run_acc(2, mk(1'b0, 1'b1, 9'h020, 3'b010, 32'h0, 32'h00000000, 1'b0));
`else
    run_acc(2, mk(1'b0, 1'b1, 9'h020, 3'b010, 32'h0, 32'h0000BEEF, 1'b0));
`endif
    @(posedge clk); #1;
    idle_bus();

    // Zero-wait responder: stores, then back-to-back loads with no idle gap
    run_acc(0, mk(1'b1, 1'b0, 9'h000, 3'b010, 32'h0BADF00D, 32'h00000000, 1'b0));
    run_acc(0, mk(1'b1, 1'b0, 9'h004, 3'b010, 32'h600DCAFE, 32'h00000000, 1'b0));
    run_acc(0, mk(1'b0, 1'b1, 9'h000, 3'b010, 32'h0,        32'h0BADF00D, 1'b0));
    run_acc(0, mk(1'b0, 1'b1, 9'h004, 3'b010, 32'h0,        32'h600DCAFE, 1'b0));
    run_acc(0, mk(1'b0, 1'b1, 9'h006, 3'b000, 32'h0,        32'h0000000D, 1'b0));
    @(posedge clk); #1;
    idle_bus();

    // Drain: every queued expectation must have been answered
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("dut2_pending", sb2.size(), 32'd0);
    chk("dut0_pending", sb0.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_W, 32, data word width.
REQ-002 Parameter DM_ADDRESS, 9, byte address width; storage is 2^DM_ADDRESS bytes, organised as 128 words.
REQ-003 Parameter WAIT_CYCLES, 2, wait states per access; legal range 0..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 MemRead  input  1  load request from the pipeline MEM stage.
REQ-007 MemWrite  input  1  store request from the pipeline MEM stage.
REQ-008 addr  input  DM_ADDRESS  byte address.
REQ-009 wr_data  input  DATA_W  store data, right-aligned.
REQ-010 func3  input  3  access size and signedness, using RV32I load/store encoding.
REQ-011 rd_data  output  DATA_W  registered load result, already extended.
REQ-012 rd_valid  output  1  one-cycle pulse marking the response cycle of an access.
REQ-013 mem_stall  output  1  pipeline hold request.
REQ-014 misalign  output  1  misaligned-access flag; present only when the Configuration macro is defined.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 In IDLE, a request (MemRead or MemWrite high) SHALL be captured, including addr, wr_data, func3 and operation.
- If both MemRead and MemWrite are high, the request is a store and the read is ignored.
REQ-017 Transitions:
- IDLE goes to WAIT, or to RESP when WAIT_CYCLES=0.
- WAIT goes to RESP after WAIT_CYCLES cycles, counted by a 4-bit down-counter.
- RESP always goes to IDLE.
REQ-018 mem_stall SHALL be combinationally high in IDLE while a request is present, and in every WAIT cycle; it SHALL be low in RESP and in IDLE with no request.
REQ-019 While mem_stall is high, the requester holds its inputs stable; the block uses only the captured copy.
REQ-020 Latency: a request first seen in cycle 0 SHALL receive rd_valid=1 in cycle WAIT_CYCLES+1, for exactly one cycle.
REQ-021 Stores SHALL commit to storage at the rising edge that ends the RESP cycle; only the selected byte lanes are written.
REQ-022 Loads SHALL update rd_data at the rising edge entering RESP; rd_data SHALL hold that value until the next load response, and stores SHALL leave it unchanged.
REQ-023 Load decoding by func3:
- 000 LB and 001 LH are sign-extended.
- 100 LBU and 101 LHU are zero-extended.
- 010 is LW.
- Any other func3 value is treated as LW.
REQ-024 Store decoding by func3: 000 SB, 001 SH, 010 SW; any other func3 value is treated as SW.
REQ-025 Byte lane is selected by addr[1:0] and half lane by addr[1]; the word index is addr[DM_ADDRESS-1:2].
REQ-026 A request present in the cycle after RESP SHALL be accepted as a new access; there is no idle gap.

Reset
REQ-027 While reset is high: state is IDLE, the counter is 0, and rd_data, rd_valid, mem_stall and misalign are all 0.
REQ-028 Reset mid-access SHALL abort the access; a pending store is dropped and no partial write occurs.
REQ-029 Storage contents SHALL NOT be altered by reset.

Configuration
REQ-030 With DMEM_MISALIGN_TRAP_EN defined, a misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL:
- complete with normal latency;
- pulse misalign together with rd_valid;
- perform no store;
- return rd_data=0.
REQ-031 Without DMEM_MISALIGN_TRAP_EN, the misalign port is absent and misaligned addresses are force-aligned: addr[0] is ignored for halfwords, and addr[1:0] are ignored for words.

Structure
REQ-032 The FSM state enum and the func3 size/sign constants SHALL reside in the shared package dmem_pkg.
REQ-033 Byte-lane selection, store mask generation and load extension SHALL be a combinational sub-module named dmem_lane_align; storage and the FSM stay in dmem_responder.

Verification
REQ-034 WAIT_CYCLES=2; SW 0xDEADBEEF to addr 0x010, then LW from 0x010 -> mem_stall high for 3 cycles per access; rd_valid in cycle 3; rd_data=0xDEADBEEF.
REQ-035 SB 0x80 to addr 0x013 over word 0x00000000; then LB 0x013 -> rd_data=0xFFFFFF80; then LBU 0x013 -> rd_data=0x00000080; then LW 0x010 -> rd_data=0x80000000.
REQ-036 WAIT_CYCLES=0; back-to-back LW 0x000 and LW 0x004 -> rd_valid in cycles 1 and 3; mem_stall high only in cycles 0 and 2.
REQ-037 Start SW 0x12345678 to 0x020; assert reset in the WAIT cycle; then LW 0x020 -> old contents returned; rd_valid never pulsed for the aborted store.
REQ-038 With DMEM_MISALIGN_TRAP_EN defined, SH to addr 0x021 -> misalign=1 with rd_valid and memory unchanged. Without the macro, the same SH writes the halfword at 0x020.
REQ-039 MemRead and MemWrite both high with wr_data=0xA5A5A5A5 at addr 0x030 -> store performed; a following LW 0x030 returns 0xA5A5A5A5.
